// File: rtl/vpu_elastic_pipe.sv
// Multi-stage valid/ready pipeline register with backpressure, synchronous flush,
// optional zeroing of empty stages and a registered occupancy count.
module vpu_elastic_pipe #(
   parameter  int WIDTH        = 32,
   parameter  int DEPTH        = 2,
   parameter  bit ZERO_INVALID = 1'b1,
   localparam int CW           = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_vld,
   output logic             in_rdy,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_vld,
   input  logic             out_rdy,
   output logic [WIDTH-1:0] out_data,
   output logic [CW-1:0]    count
);

   logic [DEPTH-1:0]            r_vld;
   logic [DEPTH-1:0][WIDTH-1:0] r_data;
   logic [CW-1:0]               r_count;

   logic [DEPTH-1:0]            w_rdy;
   logic [DEPTH-1:0]            w_vin;
   logic [DEPTH-1:0][WIDTH-1:0] w_din;
   logic                        w_push;
   logic                        w_pop;

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_stage
         // Unrolled ready chain: a stage may load unless it and every stage
         // downstream of it are full while the output is stalled.
         assign w_rdy[gi] = out_rdy || !(&r_vld[DEPTH-1:gi]);
         if (gi == 0) begin : g_head
            assign w_vin[gi] = in_vld;
            assign w_din[gi] = in_data;
         end else begin : g_body
            assign w_vin[gi] = r_vld[gi-1];
            assign w_din[gi] = r_data[gi-1];
         end
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vld  <= '0;
         r_data <= '0;
      end else if (flush) begin
         r_vld <= '0;
         if (ZERO_INVALID) r_data <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (w_rdy[i]) begin
               r_vld[i]  <= w_vin[i];
               r_data[i] <= (ZERO_INVALID && !w_vin[i]) ? '0 : w_din[i];
            end
         end
      end
   end

   assign w_push = in_vld && in_rdy;
   assign w_pop  = r_vld[DEPTH-1] && out_rdy;

   // Count tracks handshakes so it always equals the popcount of r_vld.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (flush) begin
         r_count <= '0;
      end else if (w_push && !w_pop) begin
         r_count <= r_count + CW'(1);
      end else if (!w_push && w_pop) begin
         r_count <= r_count - CW'(1);
      end
   end

   assign in_rdy   = w_rdy[0] && !flush;
   assign out_vld  = r_vld[DEPTH-1];
   assign out_data = r_data[DEPTH-1];
   assign count    = r_count;

endmodule

// File: tb/tb_vpu_elastic_pipe.sv
// Directed bench for vpu_elastic_pipe: table-driven streaming at DEPTH=2 plus
// hand-written fill, bubble, push/pop, flush and async-reset sequences.
module tb_vpu_elastic_pipe;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        in_vld = 1'b0;
   logic        out_rdy = 1'b0;
   logic [31:0] in_data = '0;

   logic        rdy2, vld2, rdy3, vld3, rdy4, vld4;
   logic [31:0] data2, data3, data4;
   logic [1:0]  cnt2, cnt3;
   logic [2:0]  cnt4;

   int nerr = 0;
   int nchk = 0;

   always #5 clk = ~clk;

   vpu_elastic_pipe #(.WIDTH(32), .DEPTH(2), .ZERO_INVALID(1'b1)) u_d2 (
      .clk(clk), .rst(rst), .flush(flush), .in_vld(in_vld), .in_rdy(rdy2),
      .in_data(in_data), .out_vld(vld2), .out_rdy(out_rdy), .out_data(data2), .count(cnt2));
   vpu_elastic_pipe #(.WIDTH(32), .DEPTH(3), .ZERO_INVALID(1'b1)) u_d3 (
      .clk(clk), .rst(rst), .flush(flush), .in_vld(in_vld), .in_rdy(rdy3),
      .in_data(in_data), .out_vld(vld3), .out_rdy(out_rdy), .out_data(data3), .count(cnt3));
   vpu_elastic_pipe #(.WIDTH(32), .DEPTH(4), .ZERO_INVALID(1'b1)) u_d4 (
      .clk(clk), .rst(rst), .flush(flush), .in_vld(in_vld), .in_rdy(rdy4),
      .in_data(in_data), .out_vld(vld4), .out_rdy(out_rdy), .out_data(data4), .count(cnt4));

   typedef struct {
      logic        iv;
      logic [31:0] id;
      logic        ordy;
      logic        ev;
      logic [31:0] ed;
      int          ec;
      logic        er;
   } vec_t;

   vec_t tv[11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Inputs are driven 1 unit after the rising edge and checked 3 units later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      flush = 1'b0;
      in_vld = 1'b0;
      out_rdy = 1'b0;
      in_data = '0;
      tick();
      rst = 1'b0;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin : main
      logic [31:0] got[$];
      int          idx;
      int          lat;
      bit          acc;
      bit          seen;

      //             iv  data      ordy  ev  exp_data  ec  er
      tv[0]  = '{1'b1, 32'h11, 1'b1, 1'b0, 32'h00, 0, 1'b1};
      tv[1]  = '{1'b1, 32'h12, 1'b1, 1'b0, 32'h00, 1, 1'b1};
      tv[2]  = '{1'b1, 32'h13, 1'b1, 1'b1, 32'h11, 2, 1'b1};
      tv[3]  = '{1'b1, 32'h14, 1'b1, 1'b1, 32'h12, 2, 1'b1};
      tv[4]  = '{1'b1, 32'h15, 1'b1, 1'b1, 32'h13, 2, 1'b1};
      tv[5]  = '{1'b1, 32'h16, 1'b1, 1'b1, 32'h14, 2, 1'b1};
      tv[6]  = '{1'b1, 32'h17, 1'b1, 1'b1, 32'h15, 2, 1'b1};
      tv[7]  = '{1'b1, 32'h18, 1'b1, 1'b1, 32'h16, 2, 1'b1};
      tv[8]  = '{1'b0, 32'h00, 1'b1, 1'b1, 32'h17, 2, 1'b1};
      tv[9]  = '{1'b0, 32'h00, 1'b1, 1'b1, 32'h18, 1, 1'b1};
      tv[10] = '{1'b0, 32'h00, 1'b1, 1'b0, 32'h00, 0, 1'b1};

      // Reset state while rst is held.
      #2;
      chk("rst_vld2", {31'b0, vld2}, 32'h0);
      chk("rst_data2", data2, 32'h0);
      chk("rst_cnt2", {30'b0, cnt2}, 32'h0);
      chk("rst_cnt4", {29'b0, cnt4}, 32'h0);
      do_reset();
      #3;
      chk("rst_inrdy2", {31'b0, rdy2}, 32'h1);
      tick();

      // Streaming, DEPTH=2.
      for (int k = 0; k < 11; k++) begin
         in_vld  = tv[k].iv;
         in_data = tv[k].id;
         out_rdy = tv[k].ordy;
         #3;
         chk($sformatf("strm%0d_vld", k), {31'b0, vld2}, {31'b0, tv[k].ev});
         chk($sformatf("strm%0d_data", k), data2, tv[k].ed);
         chk($sformatf("strm%0d_cnt", k), {30'b0, cnt2}, tv[k].ec);
         chk($sformatf("strm%0d_rdy", k), {31'b0, rdy2}, {31'b0, tv[k].er});
         tick();
      end

      // Fill DEPTH=4 under stall, then drain.
      do_reset();
      idx = 0;
      for (int c = 0; c < 8; c++) begin
         in_vld  = 1'b1;
         in_data = 32'hA0 + idx;
         #3;
         chk($sformatf("fill%0d_rdy", c), {31'b0, rdy4}, (c < 4) ? 32'h1 : 32'h0);
         if (c >= 4) begin
            chk($sformatf("fill%0d_cnt", c), {29'b0, cnt4}, 32'h4);
            chk($sformatf("fill%0d_data", c), data4, 32'hA0);
            chk($sformatf("fill%0d_vld", c), {31'b0, vld4}, 32'h1);
         end
         acc = in_vld && rdy4;
         tick();
         if (acc) idx++;
      end
      chk("fill_accepted", idx, 4);
      out_rdy = 1'b1;
      for (int c = 0; c < 20; c++) begin
         in_vld  = (idx < 6);
         in_data = 32'hA0 + idx;
         #3;
         if (vld4) got.push_back(data4);
         acc = in_vld && rdy4;
         tick();
         if (acc) idx++;
      end
      chk("drain_n", got.size(), 6);
      for (int i = 0; i < 6; i++)
         chk($sformatf("drain%0d", i), (i < got.size()) ? got[i] : 32'hDEAD, 32'hA0 + i);
      chk("drain_cnt", {29'b0, cnt4}, 32'h0);

      // Bubble collapse, DEPTH=3.
      do_reset();
      in_vld  = 1'b1;
      in_data = 32'h55;
      #3;
      chk("bub_rdy0", {31'b0, rdy3}, 32'h1);
      tick();
      in_vld = 1'b0;
      for (int c = 0; c < 5; c++) tick();
      in_vld  = 1'b1;
      in_data = 32'h56;
      #3;
      chk("bub_vld", {31'b0, vld3}, 32'h1);
      chk("bub_data", data3, 32'h55);
      chk("bub_cnt1", {30'b0, cnt3}, 32'h1);
      chk("bub_rdy1", {31'b0, rdy3}, 32'h1);
      tick();
      in_data = 32'h57;
      #3;
      chk("bub_cnt2", {30'b0, cnt3}, 32'h2);
      chk("bub_rdy2", {31'b0, rdy3}, 32'h1);
      tick();
      in_data = 32'h58;
      #3;
      chk("bub_cnt3", {30'b0, cnt3}, 32'h3);
      chk("bub_rdy3", {31'b0, rdy3}, 32'h0);
      chk("bub_hold", data3, 32'h55);
      tick();

      // Full with simultaneous push and pop, DEPTH=2.
      do_reset();
      in_vld  = 1'b1;
      in_data = 32'hB0;
      tick();
      in_data = 32'hB1;
      tick();
      out_rdy = 1'b1;
      for (int k = 0; k < 4; k++) begin
         in_data = 32'hB2 + k;
         #3;
         chk($sformatf("pp%0d_cnt", k), {30'b0, cnt2}, 32'h2);
         chk($sformatf("pp%0d_rdy", k), {31'b0, rdy2}, 32'h1);
         chk($sformatf("pp%0d_data", k), data2, 32'hB0 + k);
         tick();
      end
      in_vld = 1'b0;
      #3;
      chk("pp_tail0", data2, 32'hB4);
      tick();
      #3;
      chk("pp_tail1", data2, 32'hB5);
      chk("pp_tail_cnt", {30'b0, cnt2}, 32'h1);
      tick();

      // Flush with 3 beats held in DEPTH=4.
      do_reset();
      for (int k = 0; k < 3; k++) begin
         in_vld  = 1'b1;
         in_data = 32'hC0 + k;
         tick();
      end
      flush   = 1'b1;
      in_data = 32'hCC;
      #3;
      chk("fl_pre_cnt", {29'b0, cnt4}, 32'h3);
      chk("fl_inrdy", {31'b0, rdy4}, 32'h0);
      tick();
      flush  = 1'b0;
      in_vld = 1'b0;
      #3;
      chk("fl_vld", {31'b0, vld4}, 32'h0);
      chk("fl_cnt", {29'b0, cnt4}, 32'h0);
      chk("fl_data", data4, 32'h0);
      tick();
      out_rdy = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 6; c++) begin
         #3;
         if (vld4) seen = 1'b1;
         tick();
      end
      chk("fl_no_ghost", {31'b0, seen}, 32'h0);

      // Async reset mid-stream, DEPTH=2.
      do_reset();
      out_rdy = 1'b1;
      for (int k = 0; k < 3; k++) begin
         in_vld  = 1'b1;
         in_data = 32'hE0 + k;
         tick();
      end
      in_vld = 1'b0;
      #1;
      chk("ar_pre_vld", {31'b0, vld2}, 32'h1);
      #1;
      rst = 1'b1;
      #1;
      chk("ar_vld", {31'b0, vld2}, 32'h0);
      chk("ar_data", data2, 32'h0);
      chk("ar_cnt", {30'b0, cnt2}, 32'h0);
      chk("ar_cnt4", {29'b0, cnt4}, 32'h0);
      tick();
      rst     = 1'b0;
      in_vld  = 1'b1;
      in_data = 32'hD0;
      #3;
      chk("ar_rdy", {31'b0, rdy2}, 32'h1);
      tick();
      in_vld = 1'b0;
      lat = 1;
      for (int c = 0; c < 10; c++) begin
         #3;
         if (vld2) break;
         tick();
         lat++;
      end
      chk("ar_lat", lat, 2);
      chk("ar_first", data2, 32'hD0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

// File: doc/vpu_elastic_pipe.md
Name: vpu_elastic_pipe

Overview:
- Parametrised, multi-stage valid/ready pipeline register for the VPU datapath.
- Generalises the single-stage valid pipe register in three ways: configurable depth, downstream backpressure (ready), and synchronous flush.
- Also adds optional zeroing of invalid stage data and an occupancy count.
- Sits between VPU arithmetic stages, and between systolic-array output and VPU, wherever timing must be broken without losing data under stall.

Parameters:
- WIDTH, 32, data bits per beat.
- DEPTH, 2, number of register stages (1..16); nominal latency in cycles.
- ZERO_INVALID, 1, 1 = stage data register forced to 0 whenever its valid bit is 0; 0 = data holds last value.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous clear of all stages.
- in_vld  input  1  upstream beat valid.
- in_rdy  output  1  pipe can accept a beat this cycle.
- in_data  input  WIDTH  upstream beat data.
- out_vld  output  1  last stage holds a valid beat.
- out_rdy  input  1  downstream accepts the beat this cycle.
- out_data  output  WIDTH  last stage data.
- count  output  $clog2(DEPTH+1)  number of valid beats held (0..DEPTH).

Behaviour:
- Reset (async, rst=1):
  - All stage valid bits, stage data and count go to 0.
  - Therefore out_vld=0, out_data=0, count=0.
  - in_rdy=1 after reset release, since all stages are empty.
- Stage indexing: stage 0 is fed by in_*; stage DEPTH-1 drives out_*. Each stage has vld[i] and data[i].
- Stage advance, rdy[i] = !vld[i] || rdy[i+1], with rdy[DEPTH] = out_rdy:
  - Stage i loads from stage i-1 (or from the input for i=0) when rdy[i]=1.
  - On load, vld[i] <= vld[i-1] (or in_vld), and data[i] <= the incoming data.
  - If ZERO_INVALID=1 and the incoming valid is 0, data[i] <= 0.
  - When rdy[i]=0, stage i holds vld and data.
- Ready chain:
  - in_rdy = rdy[0] && !flush.
  - The ready path is combinational across all stages, so it is DEPTH gates deep.
  - Bubbles collapse: an empty stage accepts even when downstream is stalled.
- Transfer rules:
  - An input beat is accepted iff in_vld && in_rdy.
  - An output beat is consumed iff out_vld && out_rdy.
  - A valid stage never drops or duplicates data while stalled.
  - out_data is stable while out_vld && !out_rdy.
- Latency and throughput:
  - With out_rdy held at 1, a beat accepted at cycle t appears at out_vld/out_data at cycle t+DEPTH.
  - Throughput is 1 beat per cycle.
- Capacity:
  - At most DEPTH beats held.
  - When count==DEPTH and out_rdy=0, in_rdy=0 (full).
  - When count==DEPTH and out_rdy=1, in_rdy=1: simultaneous push and pop keeps count at DEPTH.
- count:
  - Registered; tracks accepted beats minus consumed beats.
  - Push only: +1. Pop only: -1. Both or neither: unchanged.
  - Must always equal the popcount of vld[].
- Flush (sync):
  - On the next clock edge all vld <= 0 and count <= 0.
  - If ZERO_INVALID=1, all data <= 0.
  - The input beat in the flush cycle is not accepted (in_rdy=0).
  - Whether an output beat presented in the flush cycle is consumed is determined by the out_vld && out_rdy handshake in that cycle; the flush still clears the pipe.
- Reset mid-operation: all in-flight beats are discarded immediately (async); no partial state survives.
- DEPTH=1 degenerates to a single full-throughput register slice with backpressure.

Test Plan:
- Reset, then stream 8 beats 0x11..0x18 with out_rdy=1, DEPTH=2 -> out_vld rises 2 cycles after the first accept; outputs 0x11..0x18 in order on consecutive cycles; count steady at 2 mid-stream.
- Fill with out_rdy=0, DEPTH=4, inputs 0xA0..0xA5 held valid -> exactly 0xA0..0xA3 accepted; in_rdy=0 and count=4 thereafter; out_data=0xA0 stable; raising out_rdy drains 0xA0..0xA3 then 0xA4, 0xA5 with no loss or duplication.
- Bubble collapse, DEPTH=3: one beat 0x55, then out_rdy=0 for 5 cycles -> 0x55 reaches the last stage; in_rdy stays 1 until count=3.
- Full with simultaneous push and pop, DEPTH=2: count=2, out_rdy=1, in_vld=1 for 4 cycles -> count stays 2; output order preserved.
- Flush with 3 beats held and in_vld=1 in the flush cycle -> next cycle out_vld=0, count=0, out_data=0 (ZERO_INVALID=1); the flush-cycle input is not accepted.
- Assert rst asynchronously mid-stream between clock edges -> out_vld, out_data and count go to 0 immediately without waiting for a clock edge; the first beat after release appears DEPTH cycles after its accept.
